s641_resp_misr: RTL
===================

// Module: s641_resp_misr
// PURPOSE
//  Downstream response compactor for the s641 sequential core. Each clock it
//  takes the core's 24 primary outputs as one response word and folds it into
//  a multiple-input signature register (MISR). It runs for a programmed number
//  of valid cycles, then compares the signature against a golden value.
//  Used for on-line self-test of the benchmark core without storing every
//  output vector.
// PARAMETERS
//  WIDTH       24          response / signature width (= s641 output count)
//  POLY        24'hC20001  Galois feedback mask (x^24+x^23+x^22+x^17+1, x^24 implied)
//  SEED        24'h000000  signature value loaded on START
//  NUM_CYCLES  16'd256     valid response words per run; 1..65535, 0 = elaboration error
// PORTS
//  CK          in   1      clock, rising edge
//  RST         in   1      synchronous active-high reset
//  START       in   1      1-cycle run request
//  RESP_VALID  in   1      RESP holds a valid core response this cycle
//  RESP        in   WIDTH  core outputs, bit order {G91,G94,G107,G83,...,G90}
//  GOLDEN      in   WIDTH  expected final signature
//  BUSY        out  1      run in progress
//  DONE        out  1      run finished; held until next START or RST
//  PASS        out  1      DONE && SIGNATURE==GOLDEN
//  SIGNATURE   out  WIDTH  current MISR contents
//  CYCLES      out  16     valid words folded in the current/last run
// BEHAVIOUR
//  Reset (RST=1 at an edge, any state): state=IDLE; BUSY=0, DONE=0, PASS=0,
//   SIGNATURE=0, CYCLES=0. Reset overrides START and RESP_VALID.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: START -> SIGNATURE<=SEED, CYCLES<=0, go RUN (BUSY=1 next cycle).
//   RUN : RESP_VALID=1 -> fold, CYCLES<=CYCLES+1; if CYCLES+1==NUM_CYCLES
//         go DONE on the same edge. RESP_VALID=0 -> hold everything.
//         START is ignored in RUN.
//   DONE: BUSY=0, DONE=1; SIGNATURE and CYCLES frozen. RESP_VALID ignored.
//         START -> same action as in IDLE (reseed, go RUN, DONE drops).
//  RESP_VALID in IDLE, or in the START cycle itself, is not folded.
//  Fold (registered, 1-cycle latency; word sampled at edge k is visible at k+1):
//   SIGNATURE <= {SIGNATURE[WIDTH-2:0],1'b0} ^ (SIGNATURE[WIDTH-1] ? POLY : 0) ^ RESP
//  DONE rises on the cycle after the last fold, with SIGNATURE already final.
//  PASS is combinational from DONE and the registered SIGNATURE vs the live
//   GOLDEN input; it is 0 whenever DONE=0.
//  CYCLES is 16 bits and never wraps: NUM_CYCLES bounds it.
//  BUSY=1 exactly in RUN; BUSY and DONE are never both 1.
// TESTING
//  T1 RST, NUM_CYCLES=4, SEED=0, START, 4x RESP_VALID with RESP=0 -> SIGNATURE=0,
//     CYCLES=4, DONE=1 the cycle after the 4th word, BUSY=0.
//  T2 NUM_CYCLES=2, words 24'h800000 then 24'h000000 -> SIGNATURE=24'h800000
//     after word 1, 24'hC20001 after word 2. GOLDEN=24'hC20001 -> PASS=1;
//     GOLDEN=24'hC20000 -> PASS=0.
//  T3 NUM_CYCLES=3, RESP_VALID pattern 1,0,0,1,0,1 with RESP=24'h000001 ->
//     only 3 folds, SIGNATURE=24'h000007, DONE after the 6th cycle.
//  T4 START pulsed in RUN -> ignored (CYCLES keeps counting). START in DONE ->
//     DONE=0 and SIGNATURE=SEED next cycle, CYCLES=0.
//  T5 RST asserted mid-RUN with CYCLES=2 -> next cycle all outputs at reset
//     values, RESP_VALID ignored until a new START.
//  T6 Drive from a live s641 instance: 256 cycles of random inputs, once with
//     RESP_VALID=1 throughout and once via random gaps -> both signatures match
//     a software model of the fold.

Source files
------------

// File: rtl/s641_resp_misr.sv
// Response compactor for the s641 core: folds each valid 24-bit output word
// into a Galois MISR for a fixed number of cycles, then checks against GOLDEN.
module s641_resp_misr #(
    parameter int unsigned      WIDTH      = 24,
    parameter logic [WIDTH-1:0] POLY       = 24'hC20001,
    parameter logic [WIDTH-1:0] SEED       = 24'h000000,
    parameter logic [15:0]      NUM_CYCLES = 16'd256
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    input  logic             RESP_VALID,
    input  logic [WIDTH-1:0] RESP,
    input  logic [WIDTH-1:0] GOLDEN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [WIDTH-1:0] SIGNATURE,
    output logic [15:0]      CYCLES
);

    generate
        if (NUM_CYCLES == 16'd0) begin : g_bad_num_cycles
            $error("s641_resp_misr: NUM_CYCLES must be 1..65535");
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sig;
    logic [WIDTH-1:0] sig_fold;
    logic [15:0]      cyc;
    logic [15:0]      cyc_inc;
    logic             last_word;

    // Galois step: shift left, feed back the dropped MSB, inject the word.
    always_comb begin
        sig_fold = {sig[WIDTH-2:0], 1'b0} ^ RESP;
        if (sig[WIDTH-1]) begin
            sig_fold = sig_fold ^ POLY;
        end
    end

    assign cyc_inc   = cyc + 16'd1;
    assign last_word = (cyc_inc == NUM_CYCLES);

    always_ff @(posedge CK) begin
        if (RST) begin
            state <= S_IDLE;
            sig   <= '0;
            cyc   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        state <= S_RUN;
                        sig   <= SEED;
                        cyc   <= '0;
                    end
                end
                S_RUN: begin
                    if (RESP_VALID) begin
                        sig <= sig_fold;
                        cyc <= cyc_inc;
                        if (last_word) begin
                            state <= S_DONE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY      = (state == S_RUN);
    assign DONE      = (state == S_DONE);
    assign PASS      = DONE && (sig == GOLDEN);
    assign SIGNATURE = sig;
    assign CYCLES    = cyc;

endmodule
